// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Multiplication uses one shift-add step per cycle; division is restoring with one quotient bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc, q, b;
    logic               is_div, neg_q, neg_r;
    logic               accept, sgn, dz, ge;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     sum, sh, diff;
    logic [2*WIDTH-1:0] prod;

    assign busy = state == RUN;
    assign done = state == FIN;

    always_comb begin
        accept = start && state != RUN && !flush;
        sgn    = !op[0];
        dz     = op[1] && rt == '0;
        rs_mag = sgn && rs[WIDTH-1] ? -rs : rs;
        rt_mag = sgn && rt[WIDTH-1] ? -rt : rt;
        sum    = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
        sh     = {acc, q[WIDTH-1]};
        diff   = sh - {1'b0, b};
        ge     = sh >= {1'b0, b};
        prod   = neg_q ? -{acc, q} : {acc, q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            b      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept && !op[2]) begin
            state  <= RUN;
            cnt    <= '0;
            acc    <= '0;
            is_div <= op[1];
            // A zero divisor runs unsigned on raw rs so the result lands as lo=all ones, hi=rs
            q      <= op[1] ? (dz ? rs : rs_mag) : rt_mag;
            b      <= op[1] ? rt_mag : rs_mag;
            neg_q  <= !dz && sgn && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            neg_r  <= !dz && sgn && op[1] && rs[WIDTH-1];
        end else if (state == RUN) begin
            if (cnt == LAST) begin
                state <= FIN;
                if (is_div) begin
                    lo <= neg_q ? -q : q;
                    hi <= neg_r ? -acc : acc;
                end else begin
                    {hi, lo} <= prod;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (is_div) begin
                    acc <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ge};
                end else begin
                    {acc, q} <= {sum, q[WIDTH-1:1]};
                end
            end
        end else begin
            state <= IDLE;
            if (accept && op == 3'b100) hi <= rs;
            if (accept && op == 3'b101) lo <= rs;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, flush;
    logic [2:0]   op;
    logic [W-1:0] rs, rt;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] h;
        logic [W-1:0] l;
        int           c;
        logic [2:0]   o;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi, m_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] c);
        longint p;
        if (o == 3'd0) begin
            p = longint'($signed(a)) * longint'($signed(c));
            return 64'(p);
        end
        if (o == 3'd1) return {32'b0, a} * {32'b0, c};
        if (c == 0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd3) return {a % c, a / c};
        if (a == 32'h8000_0000 && c == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'($signed(a) % $signed(c)), 32'($signed(a) / $signed(c))};
    endfunction

    function automatic logic [W-1:0] pick();
        int s = $urandom_range(0, 6);
        return s == 0 ? 32'h0 : s == 1 ? 32'h1 : s == 2 ? 32'hFFFF_FFFF :
               s == 3 ? 32'h8000_0000 : s == 4 ? 32'h7FFF_FFFF : $urandom;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    // Called at a negedge; drives one start that the next rising edge samples.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] c, input bit track);
        int n = 0;
        logic [63:0] r;
        exp_t e;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("issue_wait_busy", 32'(busy), 32'h0);
        start = 1'b1;
        op = o;
        rs = a;
        rt = c;
        if (track && !o[2]) begin
            r = ref_model(o, a, c);
            e.h = r[63:32];
            e.l = r[31:0];
            e.c = cyc + W + 2;
            e.o = o;
            sb.push_back(e);
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        if (track && o == 3'd4) m_hi = a;
        if (track && o == 3'd5) m_lo = a;
        @(negedge clk);
        start = 1'b0;
        rs = $urandom;
        rt = $urandom;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done hi=%h lo=%h required no done", hi, lo);
                end else begin
                    e = sb.pop_front();
                    if (hi !== e.h || lo !== e.l || cyc != e.c || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL result_op%0d got hi=%h lo=%h cyc=%0d busy=%b required hi=%h lo=%h cyc=%0d busy=0",
                                 e.o, hi, lo, cyc, busy, e.h, e.l, e.c);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [W-1:0] prev_hi, prev_lo;
        logic [2:0]   o;
        int           n;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = 3'd0;
        rs = '0;
        rt = '0;
        m_hi = '0;
        m_lo = '0;
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        rst_n = 1'b1;

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1);
        issue(3'd3, 32'h1234_5678, 32'h0, 1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(3'd2, 32'h8765_4321, 32'h0, 1);

        issue(3'd5, 32'h0000_ABCD, 32'h0, 1);
        chk("mtlo_lo", lo, 32'h0000_ABCD);
        chk("mtlo_hi_kept", hi, m_hi);
        chk("mtlo_busy", 32'(busy), 0);

        // Flush a MULT at its tenth RUN cycle, with a start presented on the same edge.
        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op = 3'd1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_lo", lo, 32'h0000_ABCD);
        chk("flush_hi", hi, m_hi);
        repeat (40) @(negedge clk);
        chk("flush_idle_busy", 32'(busy), 0);
        chk("flush_idle_lo", lo, 32'h0000_ABCD);

        // Starts while busy must be ignored.
        prev_hi = m_hi;
        prev_lo = m_lo;
        issue(3'd1, 32'h0001_0001, 32'h0000_FFFF, 1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op = 3'd4;
        rs = 32'hDEAD_0000;
        @(negedge clk);
        op = 3'd2;
        rs = 32'h10;
        rt = 32'h3;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore_hi", hi, prev_hi);
        chk("busy_ignore_lo", lo, prev_lo);
        chk("busy_ignore_busy", 32'(busy), 1);

        // Reset in the middle of a MULT, then start on the first edge after release.
        issue(3'd0, 32'h0000_0005, 32'h0000_0007, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd3, 32'h0000_0064, 32'h0000_0007, 1);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            issue(o, pick(), pick(), 1);
            if (o[2]) begin
                chk("mt_hi", hi, m_hi);
                chk("mt_lo", lo, m_lo);
                chk("mt_busy", 32'(busy), 0);
                chk("mt_done", 32'(done), 0);
            end
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
